// File: rtl/key_equation_solver_folded.sv
// Folded Euclidean key-equation solver for BCH over GF(2^M): one Euclidean step per
// clock on a shared datapath, producing the error locator and evaluator polynomials.
module key_equation_solver_folded #(
    parameter int M = 13,
    parameter int T = 8,
    parameter logic [M-1:0] POLY = 13'h001B,
    parameter int DW = $clog2(2*T+1)+1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*T*M-1:0]     syndromes,
    output logic                 busy,
    output logic                 done,
    output logic [(T+1)*M-1:0]   lambda,
    output logic [T*M-1:0]       omega,
    output logic [DW-1:0]        lambda_deg,
    output logic                 no_error
);
    localparam int N = 2*T;
    localparam logic signed [DW-1:0] T_DEG = DW'(T);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state_reg, state_next;

    logic [M-1:0] r_reg [N+1];
    logic [M-1:0] r_next [N+1];
    logic [M-1:0] q_reg [N+1];
    logic [M-1:0] q_next [N+1];
    logic [M-1:0] l_reg [T+1];
    logic [M-1:0] l_next [T+1];
    logic [M-1:0] u_reg [T+1];
    logic [M-1:0] u_next [T+1];
    logic signed [DW-1:0] dr_reg, dr_next, dq_reg, dq_next;

    logic [M-1:0] lambda_reg [T+1];
    logic [M-1:0] lambda_next [T+1];
    logic [M-1:0] omega_reg [T];
    logic [M-1:0] omega_next [T];
    logic [DW-1:0] deg_reg, deg_next;
    logic done_reg, done_next, no_error_reg, no_error_next;

    // Swap-normalised view of the registered state: afterwards dra >= dqa.
    logic swap;
    logic signed [DW-1:0] dra, dqa, delta;
    logic [M-1:0] ra [N+1];
    logic [M-1:0] qa [N+1];
    logic [M-1:0] la [T+1];
    logic [M-1:0] ua [T+1];
    logic [M-1:0] qs [N+1];
    logic [M-1:0] us [T+1];
    logic [M-1:0] r_upd [N+1];
    logic [M-1:0] l_upd [T+1];
    logic [M-1:0] a, b;
    logic term;
    logic [DW-1:0] ldeg;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] p;
        logic [M-1:0] s;
        p = '0;
        s = x;
        for (int i = 0; i < M; i++) begin
            if (y[i]) p = p ^ s;
            s = {s[M-2:0], 1'b0} ^ (s[M-1] ? POLY : '0);
        end
        return p;
    endfunction

    always_comb begin
        swap = (dr_reg < dq_reg);
        dra  = swap ? dq_reg : dr_reg;
        dqa  = swap ? dr_reg : dq_reg;
        for (int i = 0; i <= N; i++) begin
            ra[i] = swap ? q_reg[i] : r_reg[i];
            qa[i] = swap ? r_reg[i] : q_reg[i];
        end
        for (int i = 0; i <= T; i++) begin
            la[i] = swap ? u_reg[i] : l_reg[i];
            ua[i] = swap ? l_reg[i] : u_reg[i];
        end
    end

    always_comb begin
        a = '0;
        b = '0;
        for (int i = 0; i <= N; i++) begin
            if (DW'(i) == dra) a = ra[i];
            if (DW'(i) == dqa) b = qa[i];
        end
        delta = dra - dqa;
        // Barrel shift by delta; anything pushed past the top index falls off.
        for (int i = 0; i <= N; i++) begin
            qs[i] = '0;
            for (int k = 0; k <= i; k++)
                if (DW'(i-k) == delta) qs[i] = qa[k];
            r_upd[i] = gf_mul(b, ra[i]) ^ gf_mul(a, qs[i]);
        end
        for (int i = 0; i <= T; i++) begin
            us[i] = '0;
            for (int k = 0; k <= i; k++)
                if (DW'(i-k) == delta) us[i] = ua[k];
            l_upd[i] = gf_mul(b, la[i]) ^ gf_mul(a, us[i]);
        end
        term = (dqa < T_DEG);
        ldeg = '0;
        for (int i = 0; i <= T; i++)
            if (ua[i] != '0) ldeg = DW'(i);
    end

    always_comb begin
        state_next    = state_reg;
        r_next        = r_reg;
        q_next        = q_reg;
        l_next        = l_reg;
        u_next        = u_reg;
        dr_next       = dr_reg;
        dq_next       = dq_reg;
        lambda_next   = lambda_reg;
        omega_next    = omega_reg;
        deg_next      = deg_reg;
        no_error_next = no_error_reg;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                for (int i = 0; i <= N; i++) r_next[i] = (i == N) ? M'(1) : '0;
                for (int i = 0; i < N; i++) q_next[i] = syndromes[i*M +: M];
                q_next[N] = '0;
                for (int i = 0; i <= T; i++) begin
                    l_next[i] = '0;
                    u_next[i] = (i == 0) ? M'(1) : '0;
                end
                dr_next = DW'(N);
                dq_next = DW'(N-1);
                no_error_next = 1'b0;
                state_next = RUN;
                if (syndromes == '0) begin
                    state_next    = DONE;
                    done_next     = 1'b1;
                    no_error_next = 1'b1;
                    deg_next      = '0;
                    for (int i = 0; i <= T; i++) lambda_next[i] = (i == 0) ? M'(1) : '0;
                    for (int i = 0; i < T; i++) omega_next[i] = '0;
                end
            end
            RUN: begin
                if (term) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                    lambda_next = ua;
                    for (int i = 0; i < T; i++) omega_next[i] = qa[i];
                    deg_next = ldeg;
                end else begin
                    // Store the normalised (swapped) state so the swap takes effect.
                    r_next  = ra;
                    q_next  = qa;
                    l_next  = la;
                    u_next  = ua;
                    dr_next = dra;
                    dq_next = dqa;
                    if (a == '0) begin
                        dr_next = dra - DW'(1);
                    end else if (b == '0) begin
                        dq_next = dqa - DW'(1);
                    end else begin
                        r_next  = r_upd;
                        l_next  = l_upd;
                        dr_next = dra - DW'(1);
                    end
                end
            end
            DONE: if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            for (int i = 0; i <= N; i++) begin
                r_reg[i] <= '0;
                q_reg[i] <= '0;
            end
            for (int i = 0; i <= T; i++) begin
                l_reg[i]      <= '0;
                u_reg[i]      <= '0;
                lambda_reg[i] <= '0;
            end
            for (int i = 0; i < T; i++) omega_reg[i] <= '0;
            dr_reg       <= '0;
            dq_reg       <= '0;
            deg_reg      <= '0;
            done_reg     <= 1'b0;
            no_error_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            r_reg        <= r_next;
            q_reg        <= q_next;
            l_reg        <= l_next;
            u_reg        <= u_next;
            dr_reg       <= dr_next;
            dq_reg       <= dq_next;
            lambda_reg   <= lambda_next;
            omega_reg    <= omega_next;
            deg_reg      <= deg_next;
            done_reg     <= done_next;
            no_error_reg <= no_error_next;
        end
    end

    for (genvar gi = 0; gi <= T; gi++) begin : g_lambda
        assign lambda[gi*M +: M] = lambda_reg[gi];
    end
    for (genvar gi = 0; gi < T; gi++) begin : g_omega
        assign omega[gi*M +: M] = omega_reg[gi];
    end

    assign busy       = (state_reg == LOAD) || (state_reg == RUN);
    assign done       = done_reg;
    assign lambda_deg = deg_reg;
    assign no_error   = no_error_reg;
endmodule

// File: tb/tb_key_equation_solver_folded.sv
// Bench for the folded key-equation solver: builds syndromes from known error patterns
// and checks roots, degree, key equation and Forney magnitudes of the returned polynomials.
module tb_key_equation_solver_folded;
    localparam int M1 = 13;
    localparam int T1 = 8;
    localparam logic [M1-1:0] P1 = 13'h001B;
    localparam int DW1 = $clog2(2*T1+1)+1;
    localparam int M2 = 4;
    localparam int T2 = 2;
    localparam logic [M2-1:0] P2 = 4'h3;
    localparam int DW2 = $clog2(2*T2+1)+1;

    logic clk = 1'b0;
    logic reset, start_a, start_b;
    logic [2*T1*M1-1:0] syn_a;
    logic [2*T2*M2-1:0] syn_b;
    logic busy_a, done_a, no_error_a, busy_b, done_b, no_error_b;
    logic [(T1+1)*M1-1:0] lambda_a;
    logic [T1*M1-1:0] omega_a;
    logic [DW1-1:0] lambda_deg_a;
    logic [(T2+1)*M2-1:0] lambda_b;
    logic [T2*M2-1:0] omega_b;
    logic [DW2-1:0] lambda_deg_b;

    always #5 clk = ~clk;

    key_equation_solver_folded #(.M(M1), .T(T1), .POLY(P1)) dut (
        .clk(clk), .reset(reset), .start(start_a), .syndromes(syn_a), .busy(busy_a),
        .done(done_a), .lambda(lambda_a), .omega(omega_a), .lambda_deg(lambda_deg_a),
        .no_error(no_error_a));

    key_equation_solver_folded #(.M(M2), .T(T2), .POLY(P2)) dut_small (
        .clk(clk), .reset(reset), .start(start_b), .syndromes(syn_b), .busy(busy_b),
        .done(done_b), .lambda(lambda_b), .omega(omega_b), .lambda_deg(lambda_deg_b),
        .no_error(no_error_b));

    int checks = 0;
    int errors = 0;
    int lat;
    int pos_q[$];
    int syn[16];
    int lam[9];
    int om[8];
    int ldeg, noerr, cnt;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gmul(input int x, input int y, input int m, input int poly);
        int p = 0;
        int s = x;
        for (int i = 0; i < m; i++) begin
            if (((y >> i) & 1) == 1) p = p ^ s;
            s = s << 1;
            if (((s >> m) & 1) == 1) s = s ^ (1 << m) ^ poly;
        end
        return p;
    endfunction

    function automatic int apow(input int e, input int m, input int poly);
        int n = (1 << m) - 1;
        int r = 1;
        int base = 2;
        int k = e % n;
        if (k < 0) k = k + n;
        while (k > 0) begin
            if ((k & 1) == 1) r = gmul(r, base, m, poly);
            base = gmul(base, base, m, poly);
            k = k >> 1;
        end
        return r;
    endfunction

    task automatic gen_pos(input int count, input int n);
        int p;
        bit found;
        pos_q.delete();
        while (pos_q.size() < count) begin
            p = int'($urandom_range(n-1, 0));
            found = 1'b0;
            foreach (pos_q[k]) if (pos_q[k] == p) found = 1'b1;
            if (!found) pos_q.push_back(p);
        end
    endtask

    // Syndromes S_i = sum over error locations X_j = alpha^pos of X_j^i, unit magnitudes.
    task automatic launch(input int inst, input bit now);
        int m, t, poly, s;
        m = (inst == 0) ? M1 : M2;
        t = (inst == 0) ? T1 : T2;
        poly = (inst == 0) ? int'(P1) : int'(P2);
        for (int i = 1; i <= 2*t; i++) begin
            s = 0;
            foreach (pos_q[k]) s = s ^ apow(i * pos_q[k], m, poly);
            syn[i-1] = s;
        end
        if (!now) @(negedge clk);
        if (inst == 0) begin
            for (int i = 0; i < 2*T1; i++) syn_a[i*M1 +: M1] = M1'(syn[i]);
            start_a = 1'b1;
        end else begin
            for (int i = 0; i < 2*T2; i++) syn_b[i*M2 +: M2] = M2'(syn[i]);
            start_b = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        lat = 1;
    endtask

    task automatic finish_check(input int inst, input string tag);
        int m, t, poly, n, nu, c, ev, oe, de, xinv, xp, xprev, hi;
        bit seen;
        m = (inst == 0) ? M1 : M2;
        t = (inst == 0) ? T1 : T2;
        poly = (inst == 0) ? int'(P1) : int'(P2);
        n = (1 << m) - 1;
        seen = (inst == 0) ? done_a : done_b;
        while (!seen && lat < 2*t + 8) begin
            @(negedge clk);
            lat++;
            seen = (inst == 0) ? done_a : done_b;
        end
        check({tag, " done_seen"}, int'(seen), 1);
        if (!seen) return;
        nu = pos_q.size();
        if (nu == 0) check({tag, " latency"}, lat, 2);
        else check({tag, " latency_bound"}, int'(lat <= 2*t + 3), 1);
        if (inst == 0) begin
            for (int i = 0; i <= T1; i++) lam[i] = int'(lambda_a[i*M1 +: M1]);
            for (int i = 0; i < T1; i++) om[i] = int'(omega_a[i*M1 +: M1]);
            ldeg = int'(lambda_deg_a);
            noerr = int'(no_error_a);
        end else begin
            for (int i = 0; i <= T2; i++) lam[i] = int'(lambda_b[i*M2 +: M2]);
            for (int i = 0; i < T2; i++) om[i] = int'(omega_b[i*M2 +: M2]);
            ldeg = int'(lambda_deg_b);
            noerr = int'(no_error_b);
        end
        check({tag, " lambda_deg"}, ldeg, nu);
        hi = 0;
        for (int i = 0; i <= t; i++) if (lam[i] != 0) hi = i;
        check({tag, " lambda_top_coeff"}, hi, nu);
        check({tag, " no_error"}, noerr, int'(nu == 0));
        if (nu == 0) check({tag, " lambda0"}, lam[0], 1);
        else check({tag, " lambda0_nonzero"}, int'(lam[0] != 0), 1);
        foreach (pos_q[k]) begin
            xinv = apow(-pos_q[k], m, poly);
            ev = 0; oe = 0; de = 0; xp = 1; xprev = 1;
            for (int i = 0; i <= t; i++) begin
                ev = ev ^ gmul(lam[i], xp, m, poly);
                if (i < t) oe = oe ^ gmul(om[i], xp, m, poly);
                if ((i & 1) == 1) de = de ^ gmul(lam[i], xprev, m, poly);
                xprev = xp;
                xp = gmul(xp, xinv, m, poly);
            end
            check($sformatf("%s root@%0d", tag, pos_q[k]), ev, 0);
            check($sformatf("%s forney@%0d", tag, pos_q[k]), oe, de);
        end
        // Key equation: Lambda*S mod x^2T equals Omega, with nothing at or above x^T.
        for (int k = 0; k < 2*t; k++) begin
            c = 0;
            for (int i = 0; i <= t; i++) if (i <= k) c = c ^ gmul(lam[i], syn[k-i], m, poly);
            if (k < t) check($sformatf("%s omega[%0d]", tag, k), om[k], c);
            else check($sformatf("%s keyeq_hi[%0d]", tag, k), c, 0);
        end
        $display("solve %s inst=%0d errors=%0d latency=%0d lambda_deg=%0d", tag, inst, nu, lat, ldeg);
    endtask

    initial begin
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; syn_a = '0; syn_b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy_a), 0);
        check("reset done", int'(done_a), 0);
        check("reset lambda", int'(lambda_a != '0), 0);
        check("reset omega", int'(omega_a != '0), 0);
        check("reset lambda_deg", int'(lambda_deg_a), 0);
        check("reset no_error", int'(no_error_a), 0);
        reset = 1'b1;

        pos_q.delete();
        launch(0, 1'b0);
        finish_check(0, "zero");
        @(negedge clk);
        check("zero done_width", int'(done_a), 0);

        pos_q.delete(); pos_q.push_back(5);
        launch(0, 1'b0);
        finish_check(0, "single5");
        check("single5 ratio", lam[1], gmul(lam[0], apow(5, M1, int'(P1)), M1, int'(P1)));

        pos_q.delete(); pos_q.push_back(3); pos_q.push_back(100); pos_q.push_back(4000);
        launch(0, 1'b0);
        finish_check(0, "triple");

        for (int r = 0; r < 400; r++) begin
            gen_pos((r < 300) ? T1 : int'($urandom_range(T1, 1)), (1 << M1) - 1);
            launch(0, 1'b0);
            finish_check(0, "random");
        end

        gen_pos(4, (1 << M1) - 1);
        launch(0, 1'b0);
        repeat (2) begin @(negedge clk); lat++; end
        start_a = 1'b1;
        @(negedge clk); lat++;
        start_a = 1'b0;
        finish_check(0, "busy_start");
        cnt = 0;
        repeat (30) begin @(negedge clk); if (done_a) cnt++; end
        check("busy_start extra_done", cnt, 0);

        gen_pos(T1, (1 << M1) - 1);
        launch(0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrun busy", int'(busy_a), 0);
        check("midrun done", int'(done_a), 0);
        check("midrun lambda", int'(lambda_a != '0), 0);
        check("midrun omega", int'(omega_a != '0), 0);
        check("midrun lambda_deg", int'(lambda_deg_a), 0);
        cnt = 0;
        repeat (30) begin @(negedge clk); if (done_a) cnt++; end
        check("midrun no_done", cnt, 0);
        launch(0, 1'b0);
        finish_check(0, "after_reset");

        gen_pos(2, (1 << M2) - 1);
        launch(1, 1'b0);
        for (int r = 0; r < 20; r++) begin
            finish_check(1, "small");
            gen_pos(((r % 3) == 2) ? 1 : 2, (1 << M2) - 1);
            launch(1, 1'b1);
        end
        finish_check(1, "small");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
